// File: rtl/symbol_seq_ctrl_pkg.sv
// Shared types for the symbol sequencer: FSM states, result encodings and
// the recognizer's terminal state codes.
package symbol_seq_ctrl_pkg;

  localparam int SYM_W = 7;
  localparam int CNT_W = 5;
  localparam int GAP_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SEND,
    ST_GAP,
    ST_WAIT,
    ST_REPORT
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_ACC_A  = 2'b01,
    RES_ACC_B  = 2'b10,
    RES_REJECT = 2'b11
  } result_e;

  localparam logic [3:0] REC_REJECT = 4'b1000;
  localparam logic [3:0] REC_ACC_A  = 4'b1001;
  localparam logic [3:0] REC_ACC_B  = 4'b1010;

  function automatic logic is_terminal(input logic [3:0] code);
    return (code == REC_REJECT) || (code == REC_ACC_A) || (code == REC_ACC_B);
  endfunction

  function automatic result_e decode_result(input logic [3:0] code);
    case (code)
      REC_ACC_A:  return RES_ACC_A;
      REC_ACC_B:  return RES_ACC_B;
      REC_REJECT: return RES_REJECT;
      default:    return RES_NONE;
    endcase
  endfunction

endpackage

// File: rtl/symbol_seq_ctrl_buf.sv
// symbol_buf: append-only symbol store with write pointer, occupancy count,
// full flag and an asynchronous indexed read port.
module symbol_buf
  import symbol_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [SYM_W-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_write;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_write = wr_en && !full && !clear;

  // clear takes priority over a simultaneous append
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (do_write) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      count_d  = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign count   = count_q;

endmodule

// File: rtl/symbol_seq_ctrl.sv
// Replays buffered symbols into an external recognizer and reports its verdict.
// Optional pass/fail statistics outputs: define SYMBOL_SEQ_CTRL_STATS_EN.
module symbol_seq_ctrl
  import symbol_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       rec_state,
  output logic             rec_rst,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic [CNT_W-1:0] count,
  output logic             full
`ifdef SYMBOL_SEQ_CTRL_STATS_EN
  , output logic [7:0]     pass_cnt
  , output logic [7:0]     fail_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  result_e          result_q, result_d;

  logic [SYM_W-1:0] rd_data;
  logic [CNT_W-1:0] buf_count;
  logic             term;
  logic             last_idx;

  // The buffer is frozen while a run is in progress
  symbol_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && !busy),
    .wr_data (wr_data),
    .clear   (clear && !busy),
    .rd_idx  (index_q),
    .rd_data (rd_data),
    .count   (buf_count),
    .full    (full)
  );

  assign term     = is_terminal(rec_state);
  assign last_idx = ((CNT_W'(index_q) + CNT_W'(1)) == buf_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      gap_cnt_q <= '0;
      result_q  <= RES_NONE;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      gap_cnt_q <= gap_cnt_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    gap_cnt_d = gap_cnt_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = RES_NONE;
          state_d  = (buf_count != '0) ? ST_RST : ST_REPORT;
        end
      end
      ST_RST: begin
        index_d   = '0;
        gap_cnt_d = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (term) begin
          result_d = decode_result(rec_state);
          state_d  = ST_REPORT;
        end else if (last_idx) begin
          state_d = ST_WAIT;
        end else if (GAP > 0) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          index_d = index_q + IDX_W'(1);
        end
      end
      ST_GAP: begin
        if (term) begin
          result_d = decode_result(rec_state);
          state_d  = ST_REPORT;
        end else if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          index_d = index_q + IDX_W'(1);
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_WAIT: begin
        result_d = decode_result(rec_state);
        state_d  = ST_REPORT;
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_RST) || (state_q == ST_SEND) ||
                (state_q == ST_GAP) || (state_q == ST_WAIT);
    rec_rst   = reset || (state_q == ST_RST);
    sym_valid = (state_q == ST_SEND) && !term;
    sym_data  = sym_valid ? rd_data : '0;
    done      = (state_q == ST_REPORT);
    result    = result_q;
    count     = buf_count;
  end

`ifdef SYMBOL_SEQ_CTRL_STATS_EN
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [7:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (state_q == ST_REPORT) begin
      if ((result_q == RES_ACC_A || result_q == RES_ACC_B) && pass_cnt_q != 8'hFF) begin
        pass_cnt_d = pass_cnt_q + 8'd1;
      end
      if (result_q == RES_REJECT && fail_cnt_q != 8'hFF) begin
        fail_cnt_d = fail_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_symbol_seq_ctrl.sv
// Directed bench for symbol_seq_ctrl with a behavioural recognizer model;
// one DUT at GAP=0 and one at GAP=2 share the buffer-write inputs.
module tb_symbol_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, wr_en, clear, start0, start2;
  logic [6:0] wr_data;
  logic [3:0] rec0 = 4'd0, rec2 = 4'd0;

  logic       rr0, sv0, busy0, done0, full0;
  logic [6:0] sd0;
  logic [1:0] res0;
  logic [4:0] cnt0;
  logic       rr2, sv2, busy2, done2, full2;
  logic [6:0] sd2;
  logic [1:0] res2;
  logic [4:0] cnt2;
`ifdef SYMBOL_SEQ_CTRL_STATS_EN
  logic [7:0] pc0, fc0, pc2, fc2;
`endif

  symbol_seq_ctrl #(.DEPTH(8), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
    .start(start0), .rec_state(rec0), .rec_rst(rr0), .sym_valid(sv0),
    .sym_data(sd0), .busy(busy0), .done(done0), .result(res0), .count(cnt0),
    .full(full0)
`ifdef SYMBOL_SEQ_CTRL_STATS_EN
    , .pass_cnt(pc0), .fail_cnt(fc0)
`endif
  );

  symbol_seq_ctrl #(.DEPTH(8), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
    .start(start2), .rec_state(rec2), .rec_rst(rr2), .sym_valid(sv2),
    .sym_data(sd2), .busy(busy2), .done(done2), .result(res2), .count(cnt2),
    .full(full2)
`ifdef SYMBOL_SEQ_CTRL_STATS_EN
    , .pass_cnt(pc2), .fail_cnt(fc2)
`endif
  );

  // Recognizer: 58 6B 32 -> 1001, 28 0C 23 -> 1010, anything unexpected -> 1000
  function automatic logic [3:0] rec_next(input logic [3:0] s, input logic [6:0] d);
    if (s[3]) return s;
    case (s)
      4'd0:    return (d == 7'h58) ? 4'd1 : (d == 7'h28) ? 4'd4 : 4'b1000;
      4'd1:    return (d == 7'h6B) ? 4'd2 : 4'b1000;
      4'd2:    return (d == 7'h32) ? 4'b1001 : 4'b1000;
      4'd4:    return (d == 7'h0C) ? 4'd5 : 4'b1000;
      4'd5:    return (d == 7'h23) ? 4'b1010 : 4'b1000;
      default: return 4'b1000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rr0) rec0 <= 4'd0;
    else if (sv0) rec0 <= rec_next(rec0, sd0);
    if (rr2) rec2 <= 4'd0;
    else if (sv2) rec2 <= rec_next(rec2, sd2);
  end

  // Selected-DUT view used by the run task
  logic       sel2 = 1'b0;
  logic       cur_rr, cur_sv, cur_done;
  logic [6:0] cur_sd;
  logic [1:0] cur_res;
  assign cur_rr   = sel2 ? rr2   : rr0;
  assign cur_sv   = sel2 ? sv2   : sv0;
  assign cur_done = sel2 ? done2 : done0;
  assign cur_sd   = sel2 ? sd2   : sd0;
  assign cur_res  = sel2 ? res2  : res0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
    wr_data = 7'h00;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Start a run and follow it to done, checking strobe timing and data
  task automatic run(input bit use2, input int gap, input int n, input logic [6:0] s0,
                     input logic [6:0] s1, input logic [6:0] s2, input int done_off,
                     input logic [1:0] res, input string tag);
    logic [6:0] syms [3];
    int t, k;
    bit got_done;
    syms[0] = s0; syms[1] = s1; syms[2] = s2;
    sel2 = use2;
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    step();
    start0 = 1'b0; start2 = 1'b0;
    t = 1;
    k = 0;
    check({tag, "_rec_rst"}, t, 32'(cur_rr), 32'(n > 0));
    got_done = cur_done;
    while (!got_done && t < 40) begin
      step();
      t++;
      if (cur_sv) begin
        if (k >= n) begin
          n_cmp++; n_bad++;
          $display("FAIL %s_extra_strobe [%0d]: got %0h expected none", tag, t, cur_sd);
        end else begin
          check({tag, "_sym_time"}, k, 32'(t), 32'(2 + k * (gap + 1)));
          check({tag, "_sym_data"}, k, 32'(cur_sd), 32'(syms[k]));
        end
        k++;
      end
      got_done = cur_done;
    end
    check({tag, "_done_time"}, 0, 32'(t), 32'(done_off));
    check({tag, "_sym_count"}, 0, 32'(k), 32'(n));
    check({tag, "_result"}, 0, 32'(cur_res), 32'(res));
    step();
    check({tag, "_done_pulse"}, 0, 32'(cur_done), 32'd0);
    check({tag, "_result_hold"}, 0, 32'(cur_res), 32'(res));
  endtask

  typedef struct {
    logic       wr;
    logic [6:0] data;
    logic       clr;
    logic       st;
    logic [4:0] cnt;
    logic       busy;
    logic       done;
    logic [1:0] res;
    logic       sv;
    logic [6:0] sd;
    logic       rr;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // GAP=0 run of 58 6B 32, with writes/clear/start poked at ignored moments
    tbl[0] = '{1'b1, 7'h58, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 2'b00, 1'b0, 7'h00, 1'b0};
    tbl[1] = '{1'b1, 7'h6B, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 2'b00, 1'b0, 7'h00, 1'b0};
    tbl[2] = '{1'b1, 7'h32, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 2'b00, 1'b0, 7'h00, 1'b0};
    tbl[3] = '{1'b0, 7'h00, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 7'h00, 1'b1};
    tbl[4] = '{1'b0, 7'h00, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b1, 7'h58, 1'b0};
    tbl[5] = '{1'b1, 7'h7F, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b1, 7'h6B, 1'b0};
    tbl[6] = '{1'b0, 7'h00, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b1, 7'h32, 1'b0};
    tbl[7] = '{1'b0, 7'h00, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 7'h00, 1'b0};
    tbl[8] = '{1'b0, 7'h00, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 2'b01, 1'b0, 7'h00, 1'b0};
    tbl[9] = '{1'b0, 7'h00, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 2'b01, 1'b0, 7'h00, 1'b0};

    reset = 1'b1; wr_en = 1'b0; clear = 1'b0; start0 = 1'b0; start2 = 1'b0;
    wr_data = 7'h00;
    step();
    step();
    check("rst_busy", 0, 32'(busy0), 32'd0);
    check("rst_done", 0, 32'(done0), 32'd0);
    check("rst_sym_valid", 0, 32'(sv0), 32'd0);
    check("rst_count", 0, 32'(cnt0), 32'd0);
    check("rst_result", 0, 32'(res0), 32'd0);
    check("rst_rec_rst", 0, 32'(rr0), 32'd1);
    reset = 1'b0;
    step();
    check("post_rst_rec_rst", 0, 32'(rr0), 32'd0);

    for (int i = 0; i < 10; i++) begin
      wr_en = tbl[i].wr; wr_data = tbl[i].data; clear = tbl[i].clr; start0 = tbl[i].st;
      step();
      check("tbl_count", i, 32'(cnt0), 32'(tbl[i].cnt));
      check("tbl_busy", i, 32'(busy0), 32'(tbl[i].busy));
      check("tbl_done", i, 32'(done0), 32'(tbl[i].done));
      check("tbl_result", i, 32'(res0), 32'(tbl[i].res));
      check("tbl_sym_valid", i, 32'(sv0), 32'(tbl[i].sv));
      check("tbl_sym_data", i, 32'(sd0), 32'(tbl[i].sd));
      check("tbl_rec_rst", i, 32'(rr0), 32'(tbl[i].rr));
      $display("vec %0d: cnt=%0d busy=%0b done=%0b res=%0b sv=%0b sd=%0h rr=%0b",
               i, cnt0, busy0, done0, res0, sv0, sd0, rr0);
    end
    wr_en = 1'b0; clear = 1'b0; start0 = 1'b0;

    // clear and wr_en together: clear wins
    wr_en = 1'b1; wr_data = 7'h11; clear = 1'b1;
    step();
    wr_en = 1'b0; clear = 1'b0;
    check("clear_wins_count", 0, 32'(cnt0), 32'd0);

    // GAP=2 run: accept-B
    wr(7'h28); wr(7'h0C); wr(7'h23);
    run(1'b1, 2, 3, 7'h28, 7'h0C, 7'h23, 10, 2'b10, "gap2");
    $display("run gap2: result=%0b", res2);

    // Empty buffer start
    do_clear();
    run(1'b0, 0, 0, 7'h00, 7'h00, 7'h00, 1, 2'b00, "empty");
    $display("run empty: result=%0b", res0);

    // Early reject after the second symbol
    wr(7'h58); wr(7'h4F); wr(7'h28);
    run(1'b0, 0, 2, 7'h58, 7'h4F, 7'h00, 5, 2'b11, "early");
    $display("run early: result=%0b", res0);

    // Non-terminal at WAIT -> incomplete
    do_clear();
    wr(7'h58); wr(7'h6B);
    run(1'b0, 0, 2, 7'h58, 7'h6B, 7'h00, 5, 2'b00, "wait00");
    $display("run wait00: result=%0b", res0);

    // Fill to DEPTH and overflow
    do_clear();
    for (int i = 0; i < 7; i++) wr(7'(i + 1));
    check("fill7_full", 0, 32'(full0), 32'd0);
    wr(7'h08);
    wr(7'h09);
    check("fill_count", 0, 32'(cnt0), 32'd8);
    check("fill_full", 0, 32'(full0), 32'd1);
    $display("fill: count=%0d full=%0b", cnt0, full0);

    // Reset in the middle of SEND
    do_clear();
    wr(7'h58); wr(7'h6B); wr(7'h32);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    check("midrst_sending", 0, 32'(sv0), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_rec_rst_comb", 0, 32'(rr0), 32'd1);
    step();
    check("midrst_busy", 0, 32'(busy0), 32'd0);
    check("midrst_count", 0, 32'(cnt0), 32'd0);
    check("midrst_sym_valid", 0, 32'(sv0), 32'd0);
    check("midrst_done", 0, 32'(done0), 32'd0);
    check("midrst_rec_rst", 0, 32'(rr0), 32'd1);
    reset = 1'b0;
    step();
    check("midrst_after_done", 0, 32'(done0), 32'd0);
    check("midrst_after_busy", 0, 32'(busy0), 32'd0);
    check("midrst_after_rec_rst", 0, 32'(rr0), 32'd0);
    $display("midrst: busy=%0b count=%0d done=%0b", busy0, cnt0, done0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/symbol_seq_ctrl.md
SYMBOL_SEQ_CTRL -- requirements
Module: symbol_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, symbol buffer entries (power of two, 2..16).
REQ-002 Parameter GAP, default 0, idle cycles inserted between issued symbols (0..15).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 wr_en  in  1  append wr_data to buffer.
REQ-006 wr_data  in  7  symbol code to append.
REQ-007 clear  in  1  empty the buffer.
REQ-008 start  in  1  begin a run over buffered symbols.
REQ-009 rec_state  in  4  state code from the recognizer.
REQ-010 rec_rst  out  1  recognizer reset.
REQ-011 sym_valid  out  1  symbol strobe to recognizer.
REQ-012 sym_data  out  7  symbol code to recognizer.
REQ-013 busy  out  1  run in progress.
REQ-014 done  out  1  one-cycle run-complete pulse.
REQ-015 result  out  2  00 incomplete, 01 accept-A, 10 accept-B, 11 reject.
REQ-016 count  out  5  buffered entries; full out 1 when count==DEPTH.

Function
REQ-017 FSM states: IDLE, RST, SEND, GAP, WAIT, REPORT.
REQ-018 IDLE: start with count>0 -> RST; start with count==0 -> REPORT with result 00, no rec_rst.
REQ-019 RST: exactly one cycle; rec_rst=1; index cleared; -> SEND.
REQ-020 SEND: sym_data=buffer[index], sym_valid=1 unless rec_state terminal; last index -> WAIT, else GAP>0 -> GAP, else SEND with index+1.
REQ-021 GAP: sym_valid=0 for exactly GAP cycles, then SEND with index+1.
REQ-022 WAIT: one cycle sampling rec_state after last symbol; -> REPORT.
REQ-023 Terminal codes: 4'b1001 -> 01, 4'b1010 -> 10, 4'b1000 -> 11; any other code at WAIT -> 00.
REQ-024 Terminal rec_state seen in SEND/GAP/WAIT: sym_valid forced 0 that cycle, -> REPORT next cycle, remaining symbols not issued.
REQ-025 REPORT: done=1 one cycle, result registered and held until next start accepted; -> IDLE.
REQ-026 Latency: start at cycle T -> rec_rst at T+1, symbol k at T+2+k*(GAP+1), done one cycle after WAIT or early stop.
REQ-027 busy=1 in RST, SEND, GAP, WAIT; 0 in IDLE, REPORT.
REQ-028 wr_en ignored when busy or full; clear ignored when busy; clear and wr_en same cycle -> clear wins.
REQ-029 start ignored when busy or in REPORT; buffer contents preserved across runs.
REQ-030 sym_data=0 whenever sym_valid=0.

Reset
REQ-031 reset -> IDLE, count=0, result=00, done=0, busy=0, sym_valid=0.
REQ-032 rec_rst = reset OR state==RST, so recognizer resets with the controller, including mid-run.

Configuration
REQ-033 SYMBOL_SEQ_CTRL_STATS_EN defined: adds outputs pass_cnt (8) and fail_cnt (8), saturating at 255, incremented in REPORT for result 01/10 and 11 respectively, cleared by reset only.
REQ-034 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-035 Shared package: state enum, result encodings, recognizer terminal codes (1000, 1001, 1010), symbol width 7.
REQ-036 Sub-module symbol_buf: DEPTH x 7 storage with write pointer, count, full, indexed read.

Verification
REQ-037 Load 0x58,0x6B,0x32, GAP=0, start -> rec_rst at T+1, symbols T+2..T+4, done with result 01.
REQ-038 Load 0x28,0x0C,0x23, GAP=2 -> symbols at T+2, T+5, T+8; result 10.
REQ-039 Load 0x58,0x4F,0x28 -> recognizer reaches 1000 after second symbol; third never strobed; result 11.
REQ-040 Load 0x58,0x6B only -> WAIT sees 0010; result 00; empty buffer start -> done next cycle, result 00.
REQ-041 Fill 8 entries, 9th wr_en -> count stays 8, full=1; wr_en/clear during run ignored.
REQ-042 reset asserted mid-SEND -> next cycle IDLE, count 0, rec_rst=1 during reset, no done pulse.
